minmax_tracker: RTL and testbench

Streaming frame statistics stage that sits directly downstream of the 4-bit magnitude comparator. Accepts a frame of unsigned samples over a valid/ready handshake and uses comparator greater/equal/less results to track the running maximum, running minimum and sample count. It presents one result record per frame on an output valid/ready handshake.

---
 rtl/minmax_pkg.sv | 21 ++
 rtl/minmax_tracker_mag_compare.sv | 18 +
 rtl/minmax_tracker.sv | 145 ++++++++++++++
 tb/tb_minmax_tracker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared types and default sizes for the minmax_tracker frame statistics stage.
package minmax_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] maxv;
    logic [DEF_WIDTH-1:0] minv;
    logic [DEF_CNT_W-1:0] cnt;
    logic [DEF_CNT_W-1:0] max_idx;
    logic [DEF_CNT_W-1:0] min_idx;
  } result_t;

endpackage

// File: rtl/minmax_tracker_mag_compare.sv
// Unsigned WIDTH-bit magnitude comparator producing greater/equal/less flags.
module mag_compare
  import minmax_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             agb,
  output logic             aeb,
  output logic             alb
);

  assign agb = (a > b);
  assign aeb = (a == b);
  assign alb = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Per-frame running max/min/count over a valid/ready sample stream, one record per frame.
// Define TRACK_INDEX_EN to add first-occurrence max/min index outputs.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
`ifdef TRACK_INDEX_EN
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx,
`endif
  output logic [CNT_W-1:0] out_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] min_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             gt_max, eq_max, lt_max;
  logic             gt_min, eq_min, lt_min;
  logic             take_max, take_min;

  assign in_ready = (state != DONE) && !rst;
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  mag_compare #(.WIDTH(WIDTH)) u_cmp_max (
    .a   (in_data),
    .b   (max_q),
    .agb (gt_max),
    .aeb (eq_max),
    .alb (lt_max)
  );

  mag_compare #(.WIDTH(WIDTH)) u_cmp_min (
    .a   (in_data),
    .b   (min_q),
    .agb (gt_min),
    .aeb (eq_min),
    .alb (lt_min)
  );

  // Ties keep the earlier sample, so only a strict win replaces the extreme.
  always_comb begin
    take_max = 1'b0;
    take_min = 1'b0;
    case (1'b1)
      gt_max:         take_max = 1'b1;
      eq_max, lt_max: take_max = 1'b0;
      default:        take_max = 1'b0;
    endcase
    case (1'b1)
      lt_min:         take_min = 1'b1;
      eq_min, gt_min: take_min = 1'b0;
      default:        take_min = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      max_q     <= '0;
      min_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            max_q     <= in_data;
            min_q     <= in_data;
            cnt_q     <= CNT_W'(1);
            state     <= in_last ? DONE : ACCUM;
            out_valid <= in_last;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (take_max) max_q <= in_data;
            if (take_min) min_q <= in_data;
            cnt_q <= cnt_inc;
            if (in_last) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_max = max_q;
  assign out_min = min_q;
  assign out_cnt = cnt_q;

`ifdef TRACK_INDEX_EN
  logic [CNT_W-1:0] max_idx_q;
  logic [CNT_W-1:0] min_idx_q;

  // The pre-increment count is the 0-based position of the sample being accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        max_idx_q <= '0;
        min_idx_q <= '0;
      end else begin
        if (take_max) max_idx_q <= cnt_q;
        if (take_min) min_idx_q <= cnt_q;
      end
    end
  end

  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
// Self-checking bench for minmax_tracker: default instance plus a CNT_W=3 instance on shared stimulus.
module tb_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] in_data = 4'd0;

  logic       in_ready, out_valid;
  logic [3:0] out_max, out_min;
  logic [7:0] out_cnt;
  logic       in_ready3, out_valid3;
  logic [3:0] out_max3, out_min3;
  logic [2:0] out_cnt3;
`ifdef TRACK_INDEX_EN
  logic [7:0] out_max_idx, out_min_idx;
  logic [2:0] out_max_idx3, out_min_idx3;
`endif

  int nChecks = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  minmax_tracker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_max(out_max), .out_min(out_min),
`ifdef TRACK_INDEX_EN
    .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
`endif
    .out_cnt(out_cnt)
  );

  minmax_tracker #(.WIDTH(4), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid3),
    .out_ready(out_ready), .out_max(out_max3), .out_min(out_min3),
`ifdef TRACK_INDEX_EN
    .out_max_idx(out_max_idx3), .out_min_idx(out_min_idx3),
`endif
    .out_cnt(out_cnt3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect each frame, then derive the record from the samples as a whole.
  int frame[256];
  int flen = 0;
  bit pending = 0;
  bit started = 0;
  int exp_max[2], exp_min[2], exp_cnt[2], exp_maxi[2], exp_mini[2];
  int cw[2] = '{8, 3};

  function automatic void calcRecord(input int k);
    int sat;
    sat = (1 << cw[k]) - 1;
    exp_max[k] = frame[0];
    exp_min[k] = frame[0];
    exp_maxi[k] = 0;
    exp_mini[k] = 0;
    for (int i = 1; i < flen; i++) begin
      if (frame[i] > exp_max[k]) begin
        exp_max[k] = frame[i];
        exp_maxi[k] = (i > sat) ? sat : i;
      end
      if (frame[i] < exp_min[k]) begin
        exp_min[k] = frame[i];
        exp_mini[k] = (i > sat) ? sat : i;
      end
    end
    exp_cnt[k] = (flen > sat) ? sat : flen;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      pending = 0;
      flen = 0;
      for (int k = 0; k < 2; k++) begin
        exp_max[k] = 0; exp_min[k] = 0; exp_cnt[k] = 0; exp_maxi[k] = 0; exp_mini[k] = 0;
      end
    end else if (pending) begin
      if (out_ready) pending = 0;
    end else if (in_valid) begin
      frame[flen] = int'(in_data);
      if (flen < 255) flen = flen + 1;
      if (in_last) begin
        calcRecord(0);
        calcRecord(1);
        pending = 1;
        flen = 0;
      end
    end
  end

  // Every cycle: handshake flags always, record fields whenever no frame is partially collected.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("in_ready", in_ready, (!pending && !rst));
      checkOutput("out_valid", out_valid, pending);
      checkOutput("in_ready3", in_ready3, (!pending && !rst));
      checkOutput("out_valid3", out_valid3, pending);
      if (flen == 0) begin
        checkOutput("out_max", out_max, exp_max[0]);
        checkOutput("out_min", out_min, exp_min[0]);
        checkOutput("out_cnt", out_cnt, exp_cnt[0]);
        checkOutput("out_max3", out_max3, exp_max[1]);
        checkOutput("out_min3", out_min3, exp_min[1]);
        checkOutput("out_cnt3", out_cnt3, exp_cnt[1]);
`ifdef TRACK_INDEX_EN
        checkOutput("out_max_idx", out_max_idx, exp_maxi[0]);
        checkOutput("out_min_idx", out_min_idx, exp_mini[0]);
        checkOutput("out_max_idx3", out_max_idx3, exp_maxi[1]);
        checkOutput("out_min_idx3", out_min_idx3, exp_mini[1]);
`endif
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic l, input logic ordy);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("rst out_valid", out_valid, 0);
    checkOutput("rst out_max", out_max, 0);
    checkOutput("rst out_cnt", out_cnt, 0);
    checkOutput("rst in_ready", in_ready, 0);
    rst = 1'b0;
  endtask

  int stim[$];

  // Drives stim as one frame; returns in the cycle after the last beat was accepted.
  task automatic sendFrame(input logic ordy);
    for (int i = 0; i < stim.size(); i++)
      applyStimulus(1'b1, 4'(stim[i]), (i == stim.size() - 1), ordy);
    applyStimulus(1'b0, 4'd0, 1'b0, ordy);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyReset();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("post-reset in_ready", in_ready, 1);

    stim = '{5, 9, 2, 9, 2};
    sendFrame(1'b1);
    checkOutput("f1 out_valid", out_valid, 1);
    checkOutput("f1 max", out_max, 9);
    checkOutput("f1 min", out_min, 2);
    checkOutput("f1 cnt", out_cnt, 5);
`ifdef TRACK_INDEX_EN
    checkOutput("f1 max_idx", out_max_idx, 1);
    checkOutput("f1 min_idx", out_min_idx, 2);
`endif

    stim = '{15};
    sendFrame(1'b1);
    checkOutput("f2 max", out_max, 15);
    checkOutput("f2 min", out_min, 15);
    checkOutput("f2 cnt", out_cnt, 1);
`ifdef TRACK_INDEX_EN
    checkOutput("f2 max_idx", out_max_idx, 0);
    checkOutput("f2 min_idx", out_min_idx, 0);
`endif

    stim = '{0, 15, 0, 15};
    sendFrame(1'b1);
    checkOutput("f3 max", out_max, 15);
    checkOutput("f3 min", out_min, 0);
    checkOutput("f3 cnt", out_cnt, 4);
`ifdef TRACK_INDEX_EN
    checkOutput("f3 max_idx", out_max_idx, 1);
    checkOutput("f3 min_idx", out_min_idx, 0);
`endif

    stim = '{3, 8, 6};
    sendFrame(1'b0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
      checkOutput("bp in_ready", in_ready, 0);
      checkOutput("bp out_valid", out_valid, 1);
      checkOutput("bp max", out_max, 8);
      checkOutput("bp min", out_min, 3);
      checkOutput("bp cnt", out_cnt, 3);
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("bp released out_valid", out_valid, 0);
    checkOutput("bp released in_ready", in_ready, 1);

    stim.delete();
    for (int v = 1; v <= 9; v++) stim.push_back(v);
    sendFrame(1'b1);
    checkOutput("f5 cnt3", out_cnt3, 7);
    checkOutput("f5 max3", out_max3, 9);
    checkOutput("f5 cnt", out_cnt, 9);
    checkOutput("f5 min", out_min, 1);
`ifdef TRACK_INDEX_EN
    checkOutput("f5 max_idx3", out_max_idx3, 7);
    checkOutput("f5 max_idx", out_max_idx, 8);
`endif

    applyStimulus(1'b1, 4'd10, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b1);
    applyReset();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("mid-reset out_valid", out_valid, 0);
    checkOutput("mid-reset out_min", out_min, 0);

    stim = '{6, 2};
    sendFrame(1'b0);
    checkOutput("f7 out_valid", out_valid, 1);
    applyReset();

    stim = '{3, 4};
    sendFrame(1'b1);
    checkOutput("f8 max", out_max, 4);
    checkOutput("f8 min", out_min, 3);
    checkOutput("f8 cnt", out_cnt, 2);
    checkOutput("f8 max3", out_max3, 4);

    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
